// File: rtl/traffic_pkg.sv
// Shared constants, state encoding and per-direction output payload for the
// traffic phase arbiter.
package traffic_pkg;
    localparam int unsigned CNT_W = 4;

    localparam logic [1:0] LIGHT_RED = 2'b00;
    localparam logic [1:0] LIGHT_YEL = 2'b01;
    localparam logic [1:0] LIGHT_GRN = 2'b10;

    // Direction indices match the i_req bit order {N,S,W,E}.
    localparam logic [1:0] DIR_E = 2'd0;
    localparam logic [1:0] DIR_W = 2'd1;
    localparam logic [1:0] DIR_S = 2'd2;
    localparam logic [1:0] DIR_N = 2'd3;

    localparam logic GRP_NS = 1'b0;
    localparam logic GRP_EW = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_AR_PRE = 3'd1,
        ST_NS_G   = 3'd2,
        ST_NS_Y   = 3'd3,
        ST_AR_NS  = 3'd4,
        ST_EW_G   = 3'd5,
        ST_EW_Y   = 3'd6,
        ST_AR_EW  = 3'd7
    } state_e;

    typedef struct packed {
        logic [1:0]       wt;
        logic [CNT_W-1:0] ct;
    } dir_out_t;
endpackage

// File: rtl/traffic_phase_timer.sv
// Loadable 4-bit down counter with tick enable; shared by yellow and all-red.
module traffic_phase_timer
    import traffic_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_tick_en,
    output logic [CNT_W-1:0] o_cnt_nxt_c,
    output logic             o_last_c
);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (i_load) begin
            cnt_d = i_load_val;
        end else if (i_tick_en && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_cnt_nxt_c = cnt_d;
    assign o_last_c    = (cnt_q == CNT_W'(1));
endmodule

// File: rtl/traffic_phase_arbiter.sv
// NS/EW right-of-way controller with min/max green, demand switching and clean stop.
// Optional preemption input is enabled by defining TRAFFIC_PREEMPT_EN.
module traffic_phase_arbiter
    import traffic_pkg::*;
#(
    parameter int unsigned MIN_G = 4,
    parameter int unsigned MAX_G = 10,
    parameter int unsigned YEL   = 3,
    parameter int unsigned ALLR  = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       i_start,
    input  logic       i_tick,
    input  logic [3:0] i_req,
`ifdef TRAFFIC_PREEMPT_EN
    input  logic       i_preempt,
`endif
    output logic [1:0] o_e_wt,
    output logic [1:0] o_w_wt,
    output logic [1:0] o_s_wt,
    output logic [1:0] o_n_wt,
    output logic [3:0] o_e_ct,
    output logic [3:0] o_w_ct,
    output logic [3:0] o_s_ct,
    output logic [3:0] o_n_ct,
    output logic [2:0] o_phase
);
    localparam logic [CNT_W-1:0] MIN_G_C = CNT_W'(MIN_G);
    localparam logic [CNT_W-1:0] MAX_G_C = CNT_W'(MAX_G);
    localparam logic [CNT_W-1:0] YEL_C   = CNT_W'(YEL);
    localparam logic [CNT_W-1:0] ALLR_C  = CNT_W'(ALLR);
    localparam logic [CNT_W-1:0] G_SAT   = CNT_W'(15);

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       g_q, g_d, g_inc, green_ct;
    logic [1:0]             pend_q, pend_d, grp_req, other_pend;
    logic                   stop_q, stop_d, stop_eff, preempt;
    logic                   ns_exit, ew_exit, in_ar, entering;
    logic                   tmr_load, tmr_tick_en, tmr_last_c;
    logic [CNT_W-1:0]       tmr_load_val, tmr_cnt_d;
    dir_out_t [3:0]         out_q, out_d;

`ifdef TRAFFIC_PREEMPT_EN
    assign preempt = i_preempt;
`else
    assign preempt = 1'b0;
`endif

    assign grp_req[GRP_NS] = i_req[DIR_N] | i_req[DIR_S];
    assign grp_req[GRP_EW] = i_req[DIR_W] | i_req[DIR_E];
    assign other_pend      = pend_q | grp_req;
    assign stop_eff        = stop_q | ~i_start;
    assign g_inc           = (g_q == G_SAT) ? g_q : g_q + CNT_W'(1);
    assign in_ar           = (state_q == ST_AR_NS) || (state_q == ST_AR_EW);
    assign entering        = (state_d != state_q);

    // A request seen on the same edge as the tick counts toward the switch.
    always_comb begin
        ns_exit = i_tick && (g_inc >= MIN_G_C) &&
                  (stop_eff || (other_pend[GRP_EW] && (!grp_req[GRP_NS] || (g_inc >= MAX_G_C))));
        ew_exit = i_tick && (g_inc >= MIN_G_C) &&
                  (stop_eff || (other_pend[GRP_NS] && (!grp_req[GRP_EW] || (g_inc >= MAX_G_C))));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (i_start) state_d = ST_AR_PRE;
            ST_AR_PRE: if (i_tick && tmr_last_c) state_d = ST_NS_G;
            ST_NS_G:   if (preempt || ns_exit) state_d = ST_NS_Y;
            ST_NS_Y:   if (i_tick && tmr_last_c) state_d = ST_AR_NS;
            ST_AR_NS:  if (i_tick && tmr_last_c && !preempt) state_d = stop_eff ? ST_IDLE : ST_EW_G;
            ST_EW_G:   if (preempt || ew_exit) state_d = ST_EW_Y;
            ST_EW_Y:   if (i_tick && tmr_last_c) state_d = ST_AR_EW;
            ST_AR_EW:  if (i_tick && tmr_last_c && !preempt) state_d = stop_eff ? ST_IDLE : ST_NS_G;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Timer reloads on entry to any timed state; all-red holds at 1 under preemption.
    always_comb begin
        tmr_load     = entering && (state_d != ST_IDLE) &&
                       (state_d != ST_NS_G) && (state_d != ST_EW_G);
        tmr_load_val = ((state_d == ST_NS_Y) || (state_d == ST_EW_Y)) ? YEL_C : ALLR_C;
        tmr_tick_en  = i_tick && !(preempt && in_ar && tmr_last_c);
    end

    traffic_phase_timer u_timer (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_load      (tmr_load),
        .i_load_val  (tmr_load_val),
        .i_tick_en   (tmr_tick_en),
        .o_cnt_nxt_c (tmr_cnt_d),
        .o_last_c    (tmr_last_c)
    );

    always_comb begin
        g_d = g_q;
        if (entering && ((state_d == ST_NS_G) || (state_d == ST_EW_G))) begin
            g_d = '0;
        end else if (((state_q == ST_NS_G) || (state_q == ST_EW_G)) && i_tick) begin
            g_d = g_inc;
        end

        pend_d = pend_q | grp_req;
        if (entering && (state_d == ST_NS_G)) pend_d[GRP_NS] = 1'b0;
        if (entering && (state_d == ST_EW_G)) pend_d[GRP_EW] = 1'b0;

        stop_d = (state_q == ST_IDLE) ? 1'b0 : stop_eff;
    end

    // Output decode from next-state values so lights move on the qualifying edge.
    always_comb begin
        out_d    = '0;
        green_ct = (g_d >= MAX_G_C) ? '0 : MAX_G_C - g_d;
        case (state_d)
            ST_AR_PRE, ST_AR_NS, ST_AR_EW: begin
                out_d[DIR_E].ct = tmr_cnt_d;
                out_d[DIR_W].ct = tmr_cnt_d;
                out_d[DIR_S].ct = tmr_cnt_d;
                out_d[DIR_N].ct = tmr_cnt_d;
            end
            ST_NS_G: begin
                out_d[DIR_N] = '{wt: LIGHT_GRN, ct: green_ct};
                out_d[DIR_S] = '{wt: LIGHT_GRN, ct: green_ct};
            end
            ST_NS_Y: begin
                out_d[DIR_N] = '{wt: LIGHT_YEL, ct: tmr_cnt_d};
                out_d[DIR_S] = '{wt: LIGHT_YEL, ct: tmr_cnt_d};
            end
            ST_EW_G: begin
                out_d[DIR_E] = '{wt: LIGHT_GRN, ct: green_ct};
                out_d[DIR_W] = '{wt: LIGHT_GRN, ct: green_ct};
            end
            ST_EW_Y: begin
                out_d[DIR_E] = '{wt: LIGHT_YEL, ct: tmr_cnt_d};
                out_d[DIR_W] = '{wt: LIGHT_YEL, ct: tmr_cnt_d};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            g_q    <= '0;
            pend_q <= '0;
            stop_q <= 1'b0;
            out_q  <= '0;
        end else begin
            g_q    <= g_d;
            pend_q <= pend_d;
            stop_q <= stop_d;
            out_q  <= out_d;
        end
    end

    assign o_e_wt  = out_q[DIR_E].wt;
    assign o_w_wt  = out_q[DIR_W].wt;
    assign o_s_wt  = out_q[DIR_S].wt;
    assign o_n_wt  = out_q[DIR_N].wt;
    assign o_e_ct  = out_q[DIR_E].ct;
    assign o_w_ct  = out_q[DIR_W].ct;
    assign o_s_ct  = out_q[DIR_S].ct;
    assign o_n_ct  = out_q[DIR_N].ct;
    assign o_phase = state_q;
endmodule

// File: doc/traffic_phase_arbiter.md
# traffic_phase_arbiter

- Four-approach intersection controller that shares right-of-way between two phase groups: NS (north+south) and EW (east+west).
- Sequences each group through green, yellow and all-red with minimum and maximum green times, demand-driven switching from vehicle detectors, and a clean stop.
- Sits above the light/countdown display datapath and drives its per-direction light codes and 4-bit countdowns.

## Interface
- MIN_G, 4: minimum green, in ticks.
- MAX_G, 10: maximum green when the other group is waiting, in ticks. Legal range 1 ≤ MIN_G ≤ MAX_G ≤ 15.
- YEL, 3: yellow duration, in ticks. Legal range 1..15.
- ALLR, 1: all-red clearance, in ticks. Legal range 1..15.
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- i_start  in  1  run enable (level).
- i_tick  in  1  one-cycle timebase strobe. All durations count these strobes.
- i_req  in  4  vehicle detectors, level, bit order {N,S,W,E} = [3:0].
- o_e_wt, o_w_wt, o_s_wt, o_n_wt  out  2  light code per direction: 00 red, 01 yellow, 10 green. Code 11 is never driven.
- o_e_ct, o_w_ct, o_s_ct, o_n_ct  out  4  countdown per direction.
- o_phase  out  3  current state encoding, for debug.

## Operation
- States and transitions:
  - IDLE → AR_PRE when i_start=1.
  - AR_PRE → NS_G.
  - NS_G → NS_Y → AR_NS → EW_G → EW_Y → AR_EW → NS_G.
  - AR_NS and AR_EW go to IDLE instead if the stop flag is set.
- Timed states (Y, AR): load YEL or ALLR on entry, decrement on each i_tick, and exit on the tick where the count is 1. Each lasts exactly N ticks.
- Green states use elapsed counter g, cleared on entry and incremented per tick (saturates at 15). Exit to yellow on a tick where g+1 ≥ MIN_G and any of these holds:
  - the other group has a pending request and the own-group i_req bits are 0;
  - the other group has a pending request and g+1 ≥ MAX_G;
  - i_start=0.
- With no pending request from the other group, green rests indefinitely.
- Pending requests: a 2-bit register, one bit per group. A group's bit is set by any of its i_req bits and cleared on entry to that group's green. If set and cleared in the same cycle, clear wins.
- Stop flag:
  - set when i_start=0 is sampled in any non-IDLE state;
  - cleared in IDLE;
  - i_start re-asserting after the flag is set does not cancel the stop.
- Light codes: the active group shows green or yellow; all other directions show red. AR_*, AR_PRE and IDLE show all red.
- Countdowns:
  - green: MAX_G−g, floored at 0;
  - yellow / AR: the remaining count;
  - red directions: 0;
  - in AR, every direction shows the AR count.
- Reset values: state IDLE; all light codes 00; all countdowns 0; o_phase 0; counters 0; pending and stop flags 0.
- An asserted reset_n in mid-operation forces every output to red/0 immediately, with no yellow.

## Timing
- All outputs are registered and update on the clk edge that samples the qualifying i_tick. Latency from that tick to the output change is 1 cycle.
- i_start and i_req take effect from the first clk edge that samples them. A request present on the same edge as a qualifying tick counts for that tick.
- i_tick is held high for consecutive cycles: each cycle counts as one tick.
- Leaving IDLE requires no tick; AR_PRE is entered on the next clk edge.

## Configuration
- TRAFFIC_PREEMPT_EN defined:
  - adds input i_preempt (1 bit).
  - i_preempt=1 in a green state forces yellow on the next clk edge, ignoring MIN_G.
  - the yellow then completes normally, and AR_* holds (count stays at 1) while i_preempt=1.
  - on release, the sequence resumes to the other group.
  - i_preempt=1 in IDLE has no effect.
- TRAFFIC_PREEMPT_EN undefined: no i_preempt port and no preemption logic.

## Structure
- traffic_pkg holds:
  - light code constants (RED/YEL/GRN);
  - the state enum and its 3-bit encoding;
  - direction index constants E=0, W=1, S=2, N=3;
  - group index constants NS and EW.
- One sub-module, traffic_phase_timer: a 4-bit loadable down counter with tick enable and a terminal flag. It is instantiated once and shared by the yellow and AR states.
- The green elapsed counter and the output decode live in the top module.

## Test plan
- Reset then idle: reset_n=0 → all *_wt=00, all *_ct=0, o_phase=IDLE. With i_start=0 and ticks running, the outputs stay unchanged.
- Start with no requests: i_start=1 → AR_PRE for 1 tick, then NS green. n_ct counts 10..0, then NS stays green for 20+ ticks.
- Demand switch: i_req[1] (W) pulses during NS tick 2 → NS green ends after tick 4, NS yellow 3 ticks (ct 3,2,1), all-red 1 tick, then E/W green with the EW pending bit cleared.
- Max green: i_req=4'b1111 held → each green lasts exactly 10 ticks, with a repeating 10G/3Y/1AR cycle alternating between the groups.
- Stop: i_start=0 during EW green tick 6 → yellow 3 ticks, AR 1 tick, IDLE with all red. Re-asserting i_start during the yellow still ends in IDLE.
- Mid-op reset: reset_n=0 during NS yellow → outputs all red/0 within the reset assertion, no clock edge required. After release, the block restarts from IDLE.
